// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle processor control FSM with retired-instruction counter
module mc_controller #(
    parameter int WAIT_MEM = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        memready,
    output logic        iord,
    output logic        alusrca,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        branch,
    output logic        pcwrite,
    output logic        zeroext,
    output logic        pcen,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  aluop,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur_state;
    state_t nxt_state;
    logic   mem_ok;
    logic   retire;

    // With handshaking disabled every memory access completes in one cycle.
    assign mem_ok = (WAIT_MEM != 0) ? memready : 1'b1;

    // State register; reset returns to FETCH from anywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and Moore decode of datapath controls.
    always_comb begin
        nxt_state = S_FETCH;
        iord      = 1'b0;
        alusrca   = 1'b0;
        irwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        branch    = 1'b0;
        pcwrite   = 1'b0;
        zeroext   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 3'b000;
        case (cur_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = mem_ok;
                pcwrite   = mem_ok;
                nxt_state = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYP:      nxt_state = S_RTYPEEX;
                    OP_BEQ:       nxt_state = S_BEQEX;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_ORI:       nxt_state = S_ORIEX;
                    OP_J:         nxt_state = S_JEX;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                nxt_state = mem_ok ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg  = 1'b1;
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                memwrite  = 1'b1;
                nxt_state = mem_ok ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = 3'b011;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                regdst    = 1'b1;
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                aluop     = 3'b001;
                pcsrc     = 2'b01;
                branch    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = S_IMMWB;
            end
            S_ORIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                aluop     = 3'b010;
                zeroext   = 1'b1;
                nxt_state = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // An instruction retires only when a completing state hands back to FETCH.
    always_comb begin
        retire = 1'b0;
        if (nxt_state == S_FETCH) begin
            case (cur_state)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BEQEX, S_IMMWB, S_JEX: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= 32'd0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = cur_state;

endmodule
